// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus sizing, ROB tag width and the FU index map
// used by the CDB mux and its arbiter.
package cdb_arbiter_pkg;

   localparam int CDB_NUM_FU = 5;
   localparam int CDB_SEL_W  = 3;
   localparam int ROB_TAG_W  = 5;

   typedef enum logic [CDB_SEL_W-1:0] {
      ALU0   = 3'd0,
      ALU1   = 3'd1,
      MULT   = 3'd2,
      LSU    = 3'd3,
      BRANCH = 3'd4
   } fu_idx_e;

   function automatic int sel_bits_ok(input int n, input int w);
      return ((1 << w) >= n) ? 1 : 0;
   endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-side request/tag bundle and the registered CDB select outputs.
// master = FU/CDB side, slave = arbiter.
interface cdb_arbiter_if
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU = CDB_NUM_FU,
   parameter int SEL_W  = CDB_SEL_W,
   parameter int TAG_W  = ROB_TAG_W
);

   logic [NUM_FU-1:0]       fu_req;
   logic [NUM_FU*TAG_W-1:0] fu_rob_tag;
   logic [NUM_FU-1:0]       fu_grant;
   logic                    select_flag;
   logic [SEL_W-1:0]        select;
   logic [TAG_W-1:0]        rob_tag;

   modport master (
      output fu_req,
      output fu_rob_tag,
      input  fu_grant,
      input  select_flag,
      input  select,
      input  rob_tag
   );

   modport slave (
      input  fu_req,
      input  fu_rob_tag,
      output fu_grant,
      output select_flag,
      output select,
      output rob_tag
   );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req_i at or above
// ptr_i, wrapping modulo N. Shared with the RS issue select.
module rr_picker #(
   parameter int N = 5,
   parameter int W = 3
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] ptr_i,
   output logic         found_o,
   output logic [W-1:0] idx_o
);

   localparam int       IW = $clog2(2 * N);
   localparam logic [W:0] NV = (W + 1)'(N);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   logic [W-1:0]   off;
   logic [W:0]     sum;

   assign dbl = {req_i, req_i};

   // Rotating a doubled copy turns the wrap into a plain low-first scan.
   always_comb begin
      rot = '0;
      for (int i = 0; i < N; i++) begin
         rot[i] = dbl[IW'(ptr_i) + IW'(i)];
      end
   end

   always_comb begin
      off = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off = W'(i);
         end
      end
   end

   assign found_o = |rot;
   assign sum     = {1'b0, ptr_i} + {1'b0, off};
   assign idx_o   = (sum >= NV) ? W'(sum - NV) : sum[W-1:0];

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: round-robin choice among completed FUs, one broadcast per
// cycle, with registered grant/select/tag outputs.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU = CDB_NUM_FU,
   parameter int SEL_W  = CDB_SEL_W,
   parameter int TAG_W  = ROB_TAG_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   cdb_arbiter_if.slave bus
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_FU - 1);

   logic [SEL_W-1:0]  rr_ptr_q;
   logic [SEL_W-1:0]  rr_ptr_d;
   logic [NUM_FU-1:0] grant_q;
   logic [NUM_FU-1:0] grant_d;
   logic              flag_q;
   logic              flag_d;
   logic [SEL_W-1:0]  sel_q;
   logic [SEL_W-1:0]  sel_d;
   logic [TAG_W-1:0]  tag_q;
   logic [TAG_W-1:0]  tag_d;

   logic [NUM_FU-1:0] elig;
   logic              found;
   logic [SEL_W-1:0]  win;

   // The FU on the bus still holds its request; keep it out of the race.
   assign elig = bus.fu_req & ~grant_q;

   rr_picker #(
      .N (NUM_FU),
      .W (SEL_W)
   ) u_pick (
      .req_i   (elig),
      .ptr_i   (rr_ptr_q),
      .found_o (found),
      .idx_o   (win)
   );

   always_comb begin
      grant_d  = '0;
      flag_d   = 1'b0;
      sel_d    = '0;
      tag_d    = '0;
      rr_ptr_d = rr_ptr_q;
      if (found) begin
         grant_d  = NUM_FU'(1) << win;
         flag_d   = 1'b1;
         sel_d    = win;
         tag_d    = bus.fu_rob_tag[win*TAG_W +: TAG_W];
         rr_ptr_d = (win == LAST) ? '0 : win + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         grant_q  <= '0;
         flag_q   <= 1'b0;
         sel_q    <= '0;
         tag_q    <= '0;
         rr_ptr_q <= '0;
      end else if (flush) begin
         grant_q  <= '0;
         flag_q   <= 1'b0;
         sel_q    <= '0;
         tag_q    <= '0;
      end else begin
         grant_q  <= grant_d;
         flag_q   <= flag_d;
         sel_q    <= sel_d;
         tag_q    <= tag_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign bus.fu_grant    = grant_q;
   assign bus.select_flag = flag_q;
   assign bus.select      = sel_q;
   assign bus.rob_tag     = tag_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then FU-contract random traffic
// against a cycle-level reference model.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N  = CDB_NUM_FU;
   localparam int SW = CDB_SEL_W;
   localparam int TW = ROB_TAG_W;

   logic clock = 1'b0;
   logic reset;
   logic flush;

   cdb_arbiter_if #(.NUM_FU(N), .SEL_W(SW), .TAG_W(TW)) bus ();

   cdb_arbiter #(.NUM_FU(N), .SEL_W(SW), .TAG_W(TW)) dut (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int compared   = 0;
   int mismatched = 0;

   int            m_ptr;
   logic [N-1:0]  m_grant;
   logic          m_flag;
   logic [SW-1:0] m_sel;
   logic [TW-1:0] m_tag;
   logic [TW-1:0] tags [N];

   bit act [N];
   bit dn  [N];
   bit wt  [N];
   int wc  [N];

   task automatic chk(input string name, input logic [31:0] obs,
                      input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic step(input logic [N-1:0] req, input logic fl,
                       input logic rs);
      logic [N-1:0] elig;
      int           win;
      @(negedge clock);
      bus.fu_req = req;
      flush      = fl;
      reset      = rs;
      for (int i = 0; i < N; i++) bus.fu_rob_tag[i*TW +: TW] = tags[i];
      win = -1;
      if (!rs && !fl) begin
         elig = req & ~m_grant;
         for (int k = 0; k < N; k++) begin
            if (win < 0 && elig[(m_ptr + k) % N]) win = (m_ptr + k) % N;
         end
      end
      if (rs) m_ptr = 0;
      if (win >= 0) begin
         m_grant = N'(1) << win;
         m_flag  = 1'b1;
         m_sel   = SW'(win);
         m_tag   = tags[win];
         m_ptr   = (win + 1) % N;
      end else begin
         m_grant = '0;
         m_flag  = 1'b0;
         m_sel   = '0;
         m_tag   = '0;
      end
      @(posedge clock);
      #1;
      chk("grant", 32'(bus.fu_grant), 32'(m_grant));
      chk("flag", 32'(bus.select_flag), 32'(m_flag));
      chk("select", 32'(bus.select), 32'(m_sel));
      chk("rob_tag", 32'(bus.rob_tag), 32'(m_tag));
   endtask

   task automatic new_req(input int i);
      act[i]  = 1'b1;
      wt[i]   = 1'b1;
      wc[i]   = 0;
      tags[i] = TW'($urandom);
   endtask

   initial begin
      logic [N-1:0] req;
      logic         fl;
      logic         rs;
      reset      = 1'b1;
      flush      = 1'b0;
      bus.fu_req = '0;
      bus.fu_rob_tag = '0;
      m_ptr   = 0;
      m_grant = '0;
      m_flag  = 1'b0;
      m_sel   = '0;
      m_tag   = '0;
      for (int i = 0; i < N; i++) tags[i] = '0;

      // reset held two cycles with everyone requesting
      step(5'b11111, 1'b0, 1'b1);
      step(5'b11111, 1'b0, 1'b1);
      step(5'b11111, 1'b0, 1'b0);
      chk("rst_first_sel", 32'(bus.select), 32'(ALU0));
      step(5'b00000, 1'b0, 1'b0);

      // single requester
      tags[MULT] = 5'd7;
      step(5'b00100, 1'b0, 1'b0);
      chk("single_tag", 32'(bus.rob_tag), 32'd7);
      step(5'b00000, 1'b0, 1'b0);
      chk("single_idle", 32'(bus.select_flag), 32'd0);

      // round robin from a fresh pointer
      step(5'b00000, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) tags[i] = TW'(10 + i);
      for (int k = 0; k < 6; k++) begin
         step(5'b11111, 1'b0, 1'b0);
         chk("rr_sel", 32'(bus.select), 32'(k % N));
      end
      step(5'b00000, 1'b0, 1'b0);

      // wrap and skip from rr_ptr=4
      step(5'b01000, 1'b0, 1'b0);
      step(5'b00000, 1'b0, 1'b0);
      step(5'b00011, 1'b0, 1'b0);
      chk("wrap_fu0", 32'(bus.select), 32'd0);
      step(5'b00010, 1'b0, 1'b0);
      chk("wrap_fu1", 32'(bus.select), 32'd1);
      step(5'b00000, 1'b0, 1'b0);
      step(5'b11111, 1'b0, 1'b0);
      chk("wrap_ptr2", 32'(bus.select), 32'd2);
      step(5'b00000, 1'b0, 1'b0);

      // flush in cycle 3
      step(5'b00000, 1'b0, 1'b1);
      step(5'b11111, 1'b0, 1'b0);
      step(5'b11111, 1'b0, 1'b0);
      step(5'b11111, 1'b1, 1'b0);
      chk("flush_flag", 32'(bus.select_flag), 32'd0);
      step(5'b00000, 1'b0, 1'b0);
      step(5'b11111, 1'b0, 1'b0);
      chk("flush_resume", 32'(bus.select), 32'd2);
      step(5'b00000, 1'b0, 1'b0);
      step(5'b00000, 1'b0, 1'b0);

      // random traffic obeying the FU hold-until-grant contract
      for (int i = 0; i < N; i++) begin
         act[i] = 1'b0; dn[i] = 1'b0; wt[i] = 1'b0; wc[i] = 0;
      end
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int i = 0; i < N; i++) begin
            if (m_grant[i]) begin
               dn[i] = 1'b1;
            end else if (dn[i]) begin
               dn[i]  = 1'b0;
               act[i] = 1'b0;
               if ($urandom_range(0, 1) == 1) new_req(i);
            end else if (!act[i] && $urandom_range(0, 2) == 0) begin
               new_req(i);
            end
         end
         for (int i = 0; i < N; i++) req[i] = act[i];
         fl = ($urandom_range(0, 19) == 0);
         rs = ($urandom_range(0, 99) == 0);
         step(req, fl, rs);
         chk("onehot", 32'($onehot0(bus.fu_grant)), 32'd1);
         chk("sel_range", 32'(bus.select < SW'(N)), 32'd1);
         for (int i = 0; i < N; i++) begin
            if (bus.fu_grant[i]) begin
               wt[i] = 1'b0;
               wc[i] = 0;
            end else if (wt[i]) begin
               wc[i]++;
            end
            chk("starve", 32'(wc[i] <= N), 32'd1);
         end
         if (fl || rs) begin
            for (int i = 0; i < N; i++) begin
               act[i] = 1'b0; dn[i] = 1'b0; wt[i] = 1'b0; wc[i] = 0;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
